// File: rtl/mac8_pkg.sv
// Shared types and helpers for the mac8 streaming multiply-accumulate stage.
// Holds the frame-state enum, the product width and the saturating counter step.
package mac8_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int PROD_W = 16;

  // Increment that sticks at the all-ones value of a cnt_w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int cnt_w);
    logic [31:0] max_val;
    max_val = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/mac8_stream_accum_mul.sv
// 8x8 unsigned combinational multiplier; full 16-bit product, no registers.
module mac8_stream_accum_mul
  import mac8_pkg::*;
(
  input  logic [7:0]        i_a,
  input  logic [7:0]        i_b,
  output logic [PROD_W-1:0] o_prod
);

  assign o_prod = PROD_W'(i_a) * PROD_W'(i_b);

endmodule

// File: rtl/mac8_stream_accum.sv
// Streaming MAC: registers a product per accepted beat, sums products per frame
// and presents one (sum, beat count, overflow) result per frame over valid/ready.
module mac8_stream_accum
  import mac8_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] r_p1;
  logic              r_v1;
  logic              r_last1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  logic [ACC_W-1:0]  r_out_acc;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_out_ovf;
  logic              r_out_valid;

  logic              w_stall;
  logic              w_accept;
  logic              w_consume;
  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_nxt;
  logic              w_load;

  mac8_stream_accum_mul u_mul (
    .i_a    (in_a),
    .i_b    (in_b),
    .o_prod (w_prod)
  );

  // Only a completing frame waits for the output register; partial beats never do.
  assign w_stall   = r_v1 & r_last1 & r_out_valid & ~out_ready;
  assign in_ready  = ~r_v1 | ~w_stall;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_v1 & ~w_stall;

  assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_p1};
  assign w_carry   = w_sum[ACC_W];
  assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), CNT_W));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_load      = 1'b0;
    if (w_consume) begin
      if (r_last1) begin
        w_load      = 1'b1;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
        w_state_nxt = EMPTY;
      end else begin
        w_acc_nxt   = w_sum[ACC_W-1:0];
        w_cnt_nxt   = w_cnt_inc;
        w_ovf_nxt   = r_ovf | w_carry;
        w_state_nxt = RUN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_p1        <= '0;
      r_last1     <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_v1    <= 1'b1;
        r_p1    <= w_prod;
        r_last1 <= in_last;
      end else if (w_consume) begin
        r_v1    <= 1'b0;
      end

      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;

      // A new result may overwrite one being handed off in the same cycle.
      if (w_load) begin
        r_out_acc   <= w_sum[ACC_W-1:0];
        r_out_count <= w_cnt_inc;
        r_out_ovf   <= r_ovf | w_carry;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac8_stream_accum.sv
// Self-checking bench: default (24/8) and narrow (16/2) instances share stimulus;
// a frame-level arithmetic model predicts every delivered result.
module tb_mac8_stream_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_acc;
  logic [7:0]  out_count;
  logic        out_ovf;

  logic        in_ready_n;
  logic        out_valid_n;
  logic [15:0] out_acc_n;
  logic [1:0]  out_count_n;
  logic        out_ovf_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac8_stream_accum #(.ACC_W(24), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac8_stream_accum #(.ACC_W(16), .CNT_W(2)) u_dut_n (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_acc(out_acc_n), .out_count(out_count_n), .out_ovf(out_ovf_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: whole-frame arithmetic, results queued in frame order.
  typedef struct {
    logic [23:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
    logic [15:0] acc_n;
    logic [1:0]  cnt_n;
    logic        ovf_n;
  } exp_t;

  exp_t            q[$];
  longint unsigned m_sum = 0;
  int              m_cnt = 0;
  logic            hold  = 1'b0;
  logic [23:0]     p_acc;
  logic [7:0]      p_cnt;
  logic            p_ovf;
  logic [15:0]     p_acc_n;
  logic [1:0]      p_cnt_n;
  logic            p_ovf_n;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      m_sum = 0;
      m_cnt = 0;
      hold  = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid",   out_valid,   1);
        check("hold_acc",     out_acc,     p_acc);
        check("hold_count",   out_count,   p_cnt);
        check("hold_ovf",     out_ovf,     p_ovf);
        check("hold_acc_n",   out_acc_n,   p_acc_n);
        check("hold_count_n", out_count_n, p_cnt_n);
        check("hold_ovf_n",   out_ovf_n,   p_ovf_n);
      end
      if (out_valid) check("valid_has_expected", q.size() > 0, 1);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("res_acc",     out_acc,     e.acc);
        check("res_count",   out_count,   e.cnt);
        check("res_ovf",     out_ovf,     e.ovf);
        check("res_valid_n", out_valid_n, 1);
        check("res_acc_n",   out_acc_n,   e.acc_n);
        check("res_count_n", out_count_n, e.cnt_n);
        check("res_ovf_n",   out_ovf_n,   e.ovf_n);
      end
      if (in_valid && in_ready) begin
        m_sum += longint'(in_a) * longint'(in_b);
        m_cnt++;
        if (in_last) begin
          e.acc   = m_sum[23:0];
          e.cnt   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
          e.ovf   = (m_sum > 64'hFF_FFFF);
          e.acc_n = m_sum[15:0];
          e.cnt_n = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
          e.ovf_n = (m_sum > 64'hFFFF);
          q.push_back(e);
          m_sum = 0;
          m_cnt = 0;
        end
      end
      hold    = out_valid & ~out_ready;
      p_acc   = out_acc;   p_cnt   = out_count;   p_ovf   = out_ovf;
      p_acc_n = out_acc_n; p_cnt_n = out_count_n; p_ovf_n = out_ovf_n;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat (called at posedge+1); returns after its accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                      output int waits);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 100);
    if (!in_ready) check("send_ready_timeout", 0, 1);
    sync();
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    logic [7:0] ra, rb;
    logic [15:0] prev_prod;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) sync();
    check("rst_valid", out_valid, 0);
    check("rst_acc",   out_acc,   0);
    check("rst_count", out_count, 0);
    check("rst_ovf",   out_ovf,   0);
    check("rst_ready", in_ready,  1);
    rst = 1'b0;
    sync();

    // 1: three-beat frame, result two edges after the last beat is presented
    send(8'd3, 8'd4, 1'b0, w);
    send(8'd255, 8'd255, 1'b0, w);
    send(8'd0, 8'd9, 1'b1, w);
    @(negedge clk); check("t1_lat_not_yet", out_valid, 0);
    @(negedge clk); check("t1_lat_valid", out_valid, 1);
    check("t1_acc", out_acc, 65037);
    check("t1_count", out_count, 3);
    check("t1_ovf", out_ovf, 0);
    sync();

    // 2: wrap in the 16-bit instance, then a clean frame
    send(8'd255, 8'd255, 1'b0, w);
    send(8'd255, 8'd255, 1'b1, w);
    @(negedge clk); @(negedge clk);
    check("t2_acc_n", out_acc_n, 64514);
    check("t2_ovf_n", out_ovf_n, 1);
    check("t2_count_n", out_count_n, 2);
    check("t2_acc_wide", out_acc, 130050);
    check("t2_ovf_wide", out_ovf, 0);
    sync();
    send(8'd1, 8'd1, 1'b1, w);
    @(negedge clk); @(negedge clk);
    check("t2b_acc_n", out_acc_n, 1);
    check("t2b_ovf_n", out_ovf_n, 0);
    sync();

    // 3: back-pressured single-beat frames
    out_ready = 1'b0;
    send(8'd2, 8'd3, 1'b1, w);
    send(8'd4, 8'd5, 1'b1, w);
    check("t3_ready_low", in_ready, 0);
    check("t3_first_held", out_acc, 6);
    check("t3_valid_held", out_valid, 1);
    repeat (3) sync();
    check("t3_still_held", out_acc, 6);
    check("t3_still_low", in_ready, 0);
    out_ready = 1'b1;
    sync();
    check("t3_second", out_acc, 20);
    check("t3_second_valid", out_valid, 1);
    sync();
    check("t3_drained", out_valid, 0);

    // 4: continuous single-beat frames, full throughput
    prev_prod = '0;
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, 1'b1, w);
      check("t4_no_stall", w, 1);
      if (i > 0) begin
        check("t4_valid", out_valid, 1);
        check("t4_acc", out_acc, prev_prod);
      end
      prev_prod = 16'(ra) * 16'(rb);
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    repeat (3) sync();

    // 5: reset mid-frame with a pending result
    out_ready = 1'b0;
    send(8'd9, 8'd9, 1'b1, w);
    send(8'd1, 8'd2, 1'b0, w);
    check("t5_partial_no_stall", w, 1);
    send(8'd3, 8'd4, 1'b0, w);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    check("t5_valid0", out_valid, 0);
    check("t5_acc0", out_acc, 0);
    check("t5_count0", out_count, 0);
    check("t5_ovf0", out_ovf, 0);
    check("t5_ready1", in_ready, 1);
    out_ready = 1'b1;
    send(8'd7, 8'd7, 1'b1, w);
    @(negedge clk); @(negedge clk);
    check("t5_acc", out_acc, 49);
    check("t5_count", out_count, 1);
    sync();

    // 6: beat count saturates in the 2-bit instance
    for (int i = 0; i < 5; i++) send(8'd1, 8'd1, (i == 4), w);
    @(negedge clk); @(negedge clk);
    check("t6_acc_n", out_acc_n, 5);
    check("t6_count_n", out_count_n, 3);
    check("t6_count", out_count, 5);
    sync();

    // Random traffic and random back-pressure against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom_range(0, 255));
      in_b      = 8'($urandom_range(0, 255));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sync();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) sync();
    check("drain_valid", out_valid, 0);
    check("drain_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
